// File: rtl/branch_redirect.sv
// ----------------------------------------------------------------------------
// branch_redirect
//   Execute-side branch/jump resolver paired with the fetch stage. Resolves a
//   decoded control-flow instruction, issues a one-cycle redirect with the
//   target PC, then squashes the SHADOW wrong-path instructions that fetch had
//   already delivered. Also produces the JAL/JALR link writeback and a sticky
//   misaligned-target error.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_valid            : instruction fields valid this cycle
//   in_pc, in_imm       : instruction PC and sign-extended immediate
//   in_rs1_val/rs2_val  : register operands
//   in_funct3           : branch condition (RV32I encoding)
//   in_is_branch/jal/jalr : instruction type (priority jal > jalr > branch)
//   redirect/redirect_pc: one-cycle redirect pulse and its target
//   squash              : current in_valid instruction is wrong-path
//   link_we/link_data   : link writeback strobe and in_pc+4
//   misalign_err        : sticky misaligned-target flag
//   taken_count         : number of redirects issued (wraps)
// ----------------------------------------------------------------------------
module branch_redirect #(
    parameter int XLEN   = 32,
    parameter int SHADOW = 2,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_branch,
    input  logic            in_is_jal,
    input  logic            in_is_jalr,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            squash,
    output logic            link_we,
    output logic [XLEN-1:0] link_data,
    output logic            misalign_err,
    output logic [CNTW-1:0] taken_count
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    localparam logic [2:0] SHADOW_INIT = 3'(SHADOW);

    state_t          state_q, state_d;
    logic [2:0]      shadow_cnt_q, shadow_cnt_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            link_we_q, link_we_d;
    logic [XLEN-1:0] link_data_q, link_data_d;
    logic            misalign_q, misalign_d;
    logic [CNTW-1:0] taken_count_q, taken_count_d;

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic                   cond_true;
    logic                   is_jump;
    logic                   take;
    logic [XLEN-1:0]        target;

    assign rs1_s = in_rs1_val;
    assign rs2_s = in_rs2_val;

    // Branch condition; funct3 010/011 are reserved and simply never taken.
    always_comb begin
        cond_true = 1'b0;
        case (in_funct3)
            3'b000:  cond_true = (in_rs1_val == in_rs2_val);
            3'b001:  cond_true = (in_rs1_val != in_rs2_val);
            3'b100:  cond_true = (rs1_s <  rs2_s);
            3'b101:  cond_true = (rs1_s >= rs2_s);
            3'b110:  cond_true = (in_rs1_val <  in_rs2_val);
            3'b111:  cond_true = (in_rs1_val >= in_rs2_val);
            default: cond_true = 1'b0;
        endcase
    end

    // JAL wins over JALR, so only a lone JALR uses the register-relative target.
    always_comb begin
        is_jump = in_is_jal | in_is_jalr;
        take    = is_jump | (in_is_branch & cond_true);
        if (!in_is_jal && in_is_jalr) begin
            target = (in_rs1_val + in_imm) & ~XLEN'(1);
        end else begin
            target = in_pc + in_imm;
        end
    end

    always_comb begin
        state_d       = state_q;
        shadow_cnt_d  = shadow_cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        link_we_d     = 1'b0;
        link_data_d   = link_data_q;
        misalign_d    = misalign_q;
        taken_count_d = taken_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && take) begin
                    if (target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = target;
                        taken_count_d = taken_count_q + CNTW'(1);
                        state_d       = ST_SHADOW;
                        shadow_cnt_d  = SHADOW_INIT;
                        if (is_jump) begin
                            link_we_d   = 1'b1;
                            link_data_d = in_pc + XLEN'(4);
                        end
                    end
                end
            end
            ST_SHADOW: begin
                // Only delivered (valid) wrong-path instructions consume the shadow.
                if (in_valid) begin
                    shadow_cnt_d = shadow_cnt_q - 3'd1;
                    if (shadow_cnt_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shadow_cnt_q  <= 3'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            link_we_q     <= 1'b0;
            link_data_q   <= '0;
            misalign_q    <= 1'b0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            shadow_cnt_q  <= shadow_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            link_we_q     <= link_we_d;
            link_data_q   <= link_data_d;
            misalign_q    <= misalign_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign squash       = (state_q == ST_SHADOW) & in_valid;
    assign redirect     = redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign link_we      = link_we_q;
    assign link_data    = link_data_q;
    assign misalign_err = misalign_q;
    assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_redirect.sv
// ----------------------------------------------------------------------------
// tb_branch_redirect
//   Directed scenarios plus randomized traffic against a behavioural model of
//   the redirect/shadow rules. CNTW is reduced so counter wrap is reachable.
// ----------------------------------------------------------------------------
module tb_branch_redirect;

    localparam int XLEN   = 32;
    localparam int SHADOW = 2;
    localparam int CNTW   = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_imm = '0;
    logic [XLEN-1:0] in_rs1_val = '0;
    logic [XLEN-1:0] in_rs2_val = '0;
    logic [2:0]      in_funct3 = '0;
    logic            in_is_branch = 1'b0;
    logic            in_is_jal = 1'b0;
    logic            in_is_jalr = 1'b0;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            squash;
    logic            link_we;
    logic [XLEN-1:0] link_data;
    logic            misalign_err;
    logic [CNTW-1:0] taken_count;

    branch_redirect #(.XLEN(XLEN), .SHADOW(SHADOW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_imm(in_imm), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_funct3(in_funct3), .in_is_branch(in_is_branch),
        .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .redirect(redirect), .redirect_pc(redirect_pc), .squash(squash),
        .link_we(link_we), .link_data(link_data),
        .misalign_err(misalign_err), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          shadow_left = 0;
    bit          m_redirect = 0;
    bit          m_link_we = 0;
    bit          m_mis = 0;
    logic [31:0] m_rpc = '0;
    logic [31:0] m_ld = '0;
    int unsigned m_cnt = 0;
    bit          obs_squash;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".redirect"}, 64'(redirect), 64'(m_redirect));
        check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(m_rpc));
        check({tag, ".link_we"}, 64'(link_we), 64'(m_link_we));
        check({tag, ".link_data"}, 64'(link_data), 64'(m_ld));
        check({tag, ".misalign"}, 64'(misalign_err), 64'(m_mis));
        check({tag, ".taken_count"}, 64'(taken_count), 64'(m_cnt));
    endtask

    task automatic model_update(input bit v, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [2:0] f3, input bit br, input bit jal, input bit jalr);
        bit          taken;
        logic [31:0] tgt;
        m_redirect = 0;
        m_link_we  = 0;
        if (!v) return;
        if (shadow_left > 0) begin
            shadow_left--;
            return;
        end
        taken = 0;
        if (jal || jalr) taken = 1;
        else if (br) begin
            case (f3)
                3'd0: taken = (rs1 == rs2);
                3'd1: taken = (rs1 != rs2);
                3'd4: taken = ($signed(rs1) < $signed(rs2));
                3'd5: taken = ($signed(rs1) >= $signed(rs2));
                3'd6: taken = (rs1 < rs2);
                3'd7: taken = (rs1 >= rs2);
                default: taken = 0;
            endcase
        end
        if (!taken) return;
        if (jal) tgt = pc + imm;
        else if (jalr) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
        else tgt = pc + imm;
        if ((tgt % 4) != 0) begin
            m_mis = 1;
            return;
        end
        m_redirect  = 1;
        m_rpc       = tgt;
        m_cnt       = (m_cnt + 1) % (1 << CNTW);
        shadow_left = SHADOW;
        if (jal || jalr) begin
            m_link_we = 1;
            m_ld      = pc + 4;
        end
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0;
        in_is_branch = 0; in_is_jal = 0; in_is_jalr = 0;
        @(posedge clk); #1;
        reset = 0;
        shadow_left = 0; m_redirect = 0; m_link_we = 0; m_mis = 0;
        m_rpc = '0; m_ld = '0; m_cnt = 0;
        check_outputs("reset");
    endtask

    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [2:0] f3, input bit br, input bit jal, input bit jalr);
        in_valid = v; in_pc = pc; in_imm = imm; in_rs1_val = rs1; in_rs2_val = rs2;
        in_funct3 = f3; in_is_branch = br; in_is_jal = jal; in_is_jalr = jalr;
        #1;
        obs_squash = squash;
        check("squash", 64'(squash), 64'((shadow_left > 0) && v));
        model_update(v, pc, imm, rs1, rs2, f3, br, jal, jalr);
        @(posedge clk); #1;
        check_outputs("step");
    endtask

    task automatic nop();
        step(1, 32'h0000_0800, 32'h4, 0, 0, 3'd0, 0, 0, 0);
    endtask

    initial begin
        do_reset();

        // BEQ taken, then exactly two squashed instructions
        step(1, 32'h100, 32'h40, 5, 5, 3'b000, 1, 0, 0);
        check("beq_redirect", 64'(redirect), 64'd1);
        check("beq_pc", 64'(redirect_pc), 64'h140);
        check("beq_cnt", 64'(taken_count), 64'd1);
        nop(); check("beq_sq1", 64'(obs_squash), 64'd1);
        check("no_back2back", 64'(redirect), 64'd0);
        nop(); check("beq_sq2", 64'(obs_squash), 64'd1);
        nop(); check("beq_sq3", 64'(obs_squash), 64'd0);

        // Signed vs unsigned less-than
        step(1, 32'h300, 32'h20, 32'hFFFF_FFFF, 32'h1, 3'b100, 1, 0, 0);
        check("blt_taken", 64'(redirect), 64'd1);
        nop(); nop();
        step(1, 32'h300, 32'h20, 32'hFFFF_FFFF, 32'h1, 3'b110, 1, 0, 0);
        check("bltu_not", 64'(redirect), 64'd0);
        nop(); check("bltu_nosq", 64'(obs_squash), 64'd0);

        // JALR with bit0 cleared and link
        step(1, 32'h200, 32'h4, 32'h1001, 0, 3'd0, 0, 0, 1);
        check("jalr_pc", 64'(redirect_pc), 64'h1004);
        check("jalr_lwe", 64'(link_we), 64'd1);
        check("jalr_ld", 64'(link_data), 64'h204);
        nop(); nop();

        // Misaligned JAL: sticky error, no redirect, no link
        step(1, 32'h10, 32'h6, 0, 0, 3'd0, 0, 1, 0);
        check("mis_redirect", 64'(redirect), 64'd0);
        check("mis_lwe", 64'(link_we), 64'd0);
        check("mis_err", 64'(misalign_err), 64'd1);
        nop(); nop();
        check("mis_sticky", 64'(misalign_err), 64'd1);

        // Taken branch inside shadow is squashed
        do_reset();
        step(1, 32'h100, 32'h40, 5, 5, 3'b000, 1, 0, 0);
        step(1, 32'h500, 32'h80, 1, 1, 3'b000, 1, 0, 0);
        check("shadow_sq", 64'(obs_squash), 64'd1);
        check("shadow_noredir", 64'(redirect), 64'd0);
        nop();
        // Reset with one shadow slot remaining
        step(1, 32'h100, 32'h40, 5, 5, 3'b000, 1, 0, 0);
        nop();
        do_reset();
        nop(); check("rst_abort_sq", 64'(obs_squash), 64'd0);

        // PC wrap-around
        step(1, 32'hFFFF_FFF0, 32'h20, 0, 0, 3'b000, 1, 0, 0);
        check("wrap_pc", 64'(redirect_pc), 64'h10);
        nop(); nop();

        // Counter wrap: 2^CNTW+1 redirects
        do_reset();
        for (int i = 0; i < (1 << CNTW) + 1; i++) begin
            step(1, 32'h400, 32'h8, 0, 0, 3'b000, 1, 0, 0);
            nop(); nop();
        end
        check("cnt_wrap", 64'(taken_count), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc, imm, rs1, rs2, r;
            if (i % 60 == 0) do_reset();
            pc  = $urandom() & 32'hFFFF_FFFC;
            r   = $urandom();
            imm = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
            rs1 = $urandom();
            rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom();
            step($urandom_range(0, 3) != 0, pc, imm, rs1, rs2, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
